// File: rtl/axis_pattern_source.sv
// axis_pattern_source
//   AXI4-Stream test-traffic generator. A cfg_start pulse latches the cfg_*
//   fields and runs a sequence of packets built from a programmable data
//   pattern, with an optional idle gap between packets.
//
//   Optional feature macro: AXIS_TUSER_EN (adds M_AXIS_TUSER, SOF + packet id).
//
// Ports
//   ACLK, ARESETN        clock, asynchronous active-low reset
//   cfg_start/cfg_stop   run start / graceful stop pulses
//   cfg_mode             0 counter, 1 walking-one, 2 constant, 3 alternating
//   cfg_seed             first pattern value
//   cfg_pkt_len          beats per packet (0 rejected at start)
//   cfg_num_pkts         packets per run, 0 = continuous
//   cfg_gap              idle cycles between packets
//   M_AXIS_*             AXI4-Stream master
//   busy, done           run active / one-cycle completion pulse
//   pkt_count            packets completed in current or last run
module axis_pattern_source #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16,
   parameter int USER_WIDTH = 8
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   input  logic                    cfg_start,
   input  logic                    cfg_stop,
   input  logic [1:0]              cfg_mode,
   input  logic [DATA_WIDTH-1:0]   cfg_seed,
   input  logic [LEN_WIDTH-1:0]    cfg_pkt_len,
   input  logic [LEN_WIDTH-1:0]    cfg_num_pkts,
   input  logic [LEN_WIDTH-1:0]    cfg_gap,
   output logic                    M_AXIS_TVALID,
   input  logic                    M_AXIS_TREADY,
   output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
   output logic [DATA_WIDTH/8-1:0] M_AXIS_TKEEP,
   output logic                    M_AXIS_TLAST,
`ifdef AXIS_TUSER_EN
   output logic [USER_WIDTH-1:0]   M_AXIS_TUSER,
`endif
   output logic                    busy,
   output logic                    done,
   output logic [LEN_WIDTH-1:0]    pkt_count
);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_FINISH} state_t;

   state_t                 state_q, state_d;
   logic [1:0]             mode_q, mode_d;
   logic [DATA_WIDTH-1:0]  seed_q, seed_d;
   logic [DATA_WIDTH-1:0]  pat_q, pat_d;
   logic [LEN_WIDTH-1:0]   len_q, len_d;
   logic [LEN_WIDTH-1:0]   num_q, num_d;
   logic [LEN_WIDTH-1:0]   gap_q, gap_d;
   logic [LEN_WIDTH-1:0]   beat_q, beat_d;
   logic [LEN_WIDTH-1:0]   gcnt_q, gcnt_d;
   logic [LEN_WIDTH-1:0]   pcnt_q, pcnt_d;
   logic                   stop_q, stop_d;

   logic                   hs;
   logic                   last_beat;
   logic [LEN_WIDTH-1:0]   pcnt_inc;
   logic [DATA_WIDTH-1:0]  pat_nxt;

   assign hs        = (state_q == S_SEND) && M_AXIS_TREADY;
   assign last_beat = (beat_q == len_q - LEN_WIDTH'(1));
   assign pcnt_inc  = pcnt_q + LEN_WIDTH'(1);

   always_comb begin
      pat_nxt = pat_q;
      case (mode_q)
         2'd0:    pat_nxt = pat_q + DATA_WIDTH'(1);
         2'd1:    pat_nxt = {pat_q[DATA_WIDTH-2:0], pat_q[DATA_WIDTH-1]};
         2'd2:    pat_nxt = seed_q;
         default: pat_nxt = ~pat_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      seed_d  = seed_q;
      pat_d   = pat_q;
      len_d   = len_q;
      num_d   = num_q;
      gap_d   = gap_q;
      beat_d  = beat_q;
      gcnt_d  = gcnt_q;
      pcnt_d  = pcnt_q;
      stop_d  = stop_q;
      case (state_q)
         S_IDLE: begin
            if (cfg_start && (cfg_pkt_len != '0)) begin
               mode_d  = cfg_mode;
               seed_d  = cfg_seed;
               pat_d   = cfg_seed;
               len_d   = cfg_pkt_len;
               num_d   = cfg_num_pkts;
               gap_d   = cfg_gap;
               beat_d  = '0;
               pcnt_d  = '0;
               stop_d  = 1'b0;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            stop_d = stop_q | cfg_stop;
            if (hs) begin
               pat_d = pat_nxt;
               if (last_beat) begin
                  beat_d = '0;
                  pcnt_d = pcnt_inc;
                  // a stop arriving on the TLAST beat itself still ends the run here
                  if (((num_q != '0) && (pcnt_inc == num_q)) || stop_q || cfg_stop)
                     state_d = S_FINISH;
                  else if (gap_q != '0) begin
                     gcnt_d  = gap_q;
                     state_d = S_GAP;
                  end
               end else begin
                  beat_d = beat_q + LEN_WIDTH'(1);
               end
            end
         end
         S_GAP: begin
            // gcnt counts down to 1 so exactly gap_q cycles are spent here
            if (stop_q || cfg_stop)
               state_d = S_FINISH;
            else if (gcnt_q == LEN_WIDTH'(1))
               state_d = S_SEND;
            else
               gcnt_d = gcnt_q - LEN_WIDTH'(1);
         end
         default: begin
            stop_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q <= S_IDLE;
         mode_q  <= '0;
         seed_q  <= '0;
         pat_q   <= '0;
         len_q   <= '0;
         num_q   <= '0;
         gap_q   <= '0;
         beat_q  <= '0;
         gcnt_q  <= '0;
         pcnt_q  <= '0;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         seed_q  <= seed_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         num_q   <= num_d;
         gap_q   <= gap_d;
         beat_q  <= beat_d;
         gcnt_q  <= gcnt_d;
         pcnt_q  <= pcnt_d;
         stop_q  <= stop_d;
      end
   end

   // All outputs come straight from registers: TVALID never looks at TREADY,
   // and data/last/user only move on a handshake, so they hold during stalls.
   assign M_AXIS_TVALID = (state_q == S_SEND);
   assign M_AXIS_TLAST  = M_AXIS_TVALID && last_beat;
   assign M_AXIS_TDATA  = pat_q;
   assign M_AXIS_TKEEP  = '1;
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_FINISH);
   assign pkt_count     = pcnt_q;

`ifdef AXIS_TUSER_EN
   // Upper bits are the packet index modulo 2^(USER_WIDTH-1); needs USER_WIDTH-1 <= LEN_WIDTH.
   assign M_AXIS_TUSER = {pcnt_q[USER_WIDTH-2:0], M_AXIS_TVALID && (beat_q == '0)};
`endif

endmodule

// File: tb/tb_axis_pattern_source.sv
// Self-checking bench for axis_pattern_source: directed and randomized runs,
// compared against an arithmetic model of the pattern sequence.
module tb_axis_pattern_source;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic        cfg_start = 1'b0, cfg_stop = 1'b0;
   logic [1:0]  cfg_mode = '0;
   logic [31:0] cfg_seed = '0;
   logic [15:0] cfg_pkt_len = '0, cfg_num_pkts = '0, cfg_gap = '0;
   logic        M_AXIS_TVALID, M_AXIS_TREADY = 1'b1, M_AXIS_TLAST;
   logic [31:0] M_AXIS_TDATA;
   logic [3:0]  M_AXIS_TKEEP;
   logic        busy, done;
   logic [15:0] pkt_count;
`ifdef AXIS_TUSER_EN
   logic [7:0]  M_AXIS_TUSER;
`endif

   axis_pattern_source dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_mode(cfg_mode),
      .cfg_seed(cfg_seed), .cfg_pkt_len(cfg_pkt_len), .cfg_num_pkts(cfg_num_pkts),
      .cfg_gap(cfg_gap),
      .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
      .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP),
      .M_AXIS_TLAST(M_AXIS_TLAST),
`ifdef AXIS_TUSER_EN
      .M_AXIS_TUSER(M_AXIS_TUSER),
`endif
      .busy(busy), .done(done), .pkt_count(pkt_count)
   );

   always #5 ACLK = ~ACLK;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // beats captured by the monitor
   logic [31:0] dq[$];
   bit          lq[$];
   int          cq[$];
   logic [7:0]  uq[$];

   // monitor: samples at negedge (inputs change at posedge+1)
   bit          stall_q = 0;
   logic [31:0] hold_d;
   logic        hold_l;
   logic [7:0]  hold_u;
   logic [7:0]  cur_u;

   always @(negedge ACLK) begin
      cyc++;
`ifdef AXIS_TUSER_EN
      cur_u = M_AXIS_TUSER;
`else
      cur_u = 8'h00;
`endif
      if (ARESETN) begin
         if (stall_q) begin
            checks++;
            if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== hold_d || M_AXIS_TLAST !== hold_l || cur_u !== hold_u) begin
               errors++;
               $display("FAIL stall_hold: valid=%b data=%h last=%b user=%h, required valid=1 data=%h last=%b user=%h",
                        M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, cur_u, hold_d, hold_l, hold_u);
            end
         end
         if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            dq.push_back(M_AXIS_TDATA);
            lq.push_back(M_AXIS_TLAST);
            cq.push_back(cyc);
            uq.push_back(cur_u);
         end
         stall_q = M_AXIS_TVALID && !M_AXIS_TREADY;
         hold_d  = M_AXIS_TDATA;
         hold_l  = M_AXIS_TLAST;
         hold_u  = cur_u;
      end else begin
         stall_q = 0;
      end
   end

   // reference: k-th beat of a run, straight from the pattern definitions
   function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] s, input int k);
      int r;
      r = k % 32;
      case (m)
         2'd0:    return s + 32'(k);
         2'd1:    return (r == 0) ? s : ((s << r) | (s >> (32 - r)));
         2'd2:    return s;
         default: return (k % 2 == 1) ? ~s : s;
      endcase
   endfunction

   task automatic clear_mon();
      dq.delete(); lq.delete(); cq.delete(); uq.delete();
   endtask

   // one-cycle start pulse; afterwards the cfg_* inputs are scrambled
   task automatic start_run(input logic [1:0] m, input logic [31:0] s,
                            input logic [15:0] l, input logic [15:0] n, input logic [15:0] g);
      @(posedge ACLK); #1;
      cfg_start = 1'b1; cfg_mode = m; cfg_seed = s;
      cfg_pkt_len = l; cfg_num_pkts = n; cfg_gap = g;
      @(posedge ACLK); #1;
      cfg_start = 1'b0;
      cfg_mode = 2'($urandom); cfg_seed = $urandom;
      cfg_pkt_len = 16'($urandom_range(1, 9)); cfg_num_pkts = 16'($urandom);
      cfg_gap = 16'($urandom_range(0, 7));
   endtask

   task automatic wait_done(input int limit, output bit ok, output logic [15:0] pc);
      ok = 0; pc = '0;
      for (int i = 0; i < limit; i++) begin
         @(negedge ACLK);
         if (done) begin ok = 1; pc = pkt_count; break; end
      end
   endtask

   task automatic test_reset();
      ARESETN = 1'b0;
      #12;
      checks++;
      if (M_AXIS_TVALID !== 1'b0 || M_AXIS_TLAST !== 1'b0 || M_AXIS_TDATA !== 32'h0 ||
          busy !== 1'b0 || done !== 1'b0 || pkt_count !== 16'h0 || M_AXIS_TKEEP !== 4'hF) begin
         errors++;
         $display("FAIL reset_state: valid=%b last=%b data=%h busy=%b done=%b cnt=%0d keep=%h, required 0/0/0/0/0/0/f",
                  M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, busy, done, pkt_count, M_AXIS_TKEEP);
      end
      @(posedge ACLK); #1;
      ARESETN = 1'b1;
   endtask

   task automatic test_counter();
      bit ok; logic [15:0] pc; int t0;
      // stop in IDLE must not leak into the next run
      @(posedge ACLK); #1; cfg_stop = 1'b1;
      @(posedge ACLK); #1; cfg_stop = 1'b0;
      clear_mon();
      M_AXIS_TREADY = 1'b1;
      start_run(2'd0, 32'h1, 16'd4, 16'd2, 16'd0);
      t0 = cyc;
      checks++;
      if (busy !== 1'b1 || M_AXIS_TVALID !== 1'b1) begin
         errors++; $display("FAIL counter_start: busy=%b valid=%b, required 1/1", busy, M_AXIS_TVALID);
      end
      wait_done(100, ok, pc);
      checks++;
      if (!ok || pc !== 16'd2 || dq.size() != 8) begin
         errors++; $display("FAIL counter_done: done_seen=%0d cnt=%0d beats=%0d, required 1/2/8", ok, pc, dq.size());
      end
      for (int k = 0; k < dq.size() && k < 8; k++) begin
         checks++;
         if (dq[k] !== 32'(k + 1) || lq[k] !== (k == 3 || k == 7) || cq[k] != t0 + 1 + k ||
             uq[k] !== ((k % 4 == 0) ? 8'(((k / 4) << 1) | 1) : 8'((k / 4) << 1)) && 0) begin
            errors++;
            $display("FAIL counter_beat%0d: data=%h last=%b cyc=%0d, required data=%h last=%b cyc=%0d",
                     k, dq[k], lq[k], cq[k], 32'(k + 1), (k == 3 || k == 7), t0 + 1 + k);
         end
`ifdef AXIS_TUSER_EN
         checks++;
         if (uq[k] !== {7'(k / 4), k % 4 == 0}) begin
            errors++; $display("FAIL counter_tuser%0d: user=%h, required %h", k, uq[k], {7'(k / 4), k % 4 == 0});
         end
`endif
      end
      @(negedge ACLK);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || pkt_count !== 16'd2) begin
         errors++; $display("FAIL counter_after: done=%b busy=%b cnt=%0d, required 0/0/2", done, busy, pkt_count);
      end
   endtask

   task automatic test_backpressure();
      bit got; logic [15:0] pc, len; logic [31:0] seed; int nb;
      len = 16'($urandom_range(1, 6));
      seed = $urandom;
      clear_mon();
      M_AXIS_TREADY = 1'b1;
      start_run(2'd0, seed, len, 16'd0, 16'd0);
      got = 0; pc = '0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(posedge ACLK); #1;
         cfg_stop = (i == 100);
         M_AXIS_TREADY = 1'($urandom_range(0, 1));
         @(negedge ACLK);
         if (done) begin got = 1; pc = pkt_count; end
      end
      cfg_stop = 1'b0;
      M_AXIS_TREADY = 1'b1;
      nb = dq.size();
      checks++;
      if (!got || nb == 0 || nb % int'(len) != 0 || int'(pc) != nb / int'(len)) begin
         errors++; $display("FAIL bp_count: done_seen=%0d beats=%0d len=%0d cnt=%0d", got, nb, len, pc);
      end
      for (int k = 0; k < nb; k++) begin
         checks++;
         if (dq[k] !== model(2'd0, seed, k) || lq[k] !== (k % int'(len) == int'(len) - 1)) begin
            errors++; $display("FAIL bp_beat%0d: data=%h last=%b, required data=%h last=%b",
                               k, dq[k], lq[k], model(2'd0, seed, k), (k % int'(len) == int'(len) - 1));
         end
      end
   endtask

   task automatic test_gap_wrap();
      bit ok; logic [15:0] pc;
      logic [31:0] exp [6];
      exp = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h2, 32'h3};
      clear_mon();
      start_run(2'd0, 32'hFFFFFFFE, 16'd3, 16'd2, 16'd5);
      wait_done(100, ok, pc);
      checks++;
      if (!ok || pc !== 16'd2 || dq.size() != 6) begin
         errors++; $display("FAIL gap_done: done_seen=%0d cnt=%0d beats=%0d, required 1/2/6", ok, pc, dq.size());
      end
      for (int k = 0; k < dq.size() && k < 6; k++) begin
         checks++;
         if (dq[k] !== exp[k] || lq[k] !== (k == 2 || k == 5)) begin
            errors++; $display("FAIL gap_beat%0d: data=%h last=%b, required data=%h last=%b",
                               k, dq[k], lq[k], exp[k], (k == 2 || k == 5));
         end
      end
      if (dq.size() == 6) begin
         checks++;
         if (cq[3] - cq[2] != 6 || cq[1] - cq[0] != 1) begin
            errors++; $display("FAIL gap_len: idle=%0d, required 5", cq[3] - cq[2] - 1);
         end
      end
   endtask

   task automatic test_stop();
      bit ok; logic [15:0] pc; logic [31:0] seed;
      seed = $urandom;
      clear_mon();
      M_AXIS_TREADY = 1'b1;
      start_run(2'd0, seed, 16'd8, 16'd0, 16'd0);
      repeat (34) begin @(posedge ACLK); #1; end   // beat 3 of packet 5
      cfg_stop = 1'b1;
      @(posedge ACLK); #1;
      cfg_stop = 1'b0;
      wait_done(100, ok, pc);
      checks++;
      if (!ok || pc !== 16'd5 || dq.size() != 40) begin
         errors++; $display("FAIL stop_done: done_seen=%0d cnt=%0d beats=%0d, required 1/5/40", ok, pc, dq.size());
      end
      for (int k = 0; k < dq.size(); k++) begin
         checks++;
         if (dq[k] !== model(2'd0, seed, k) || lq[k] !== (k % 8 == 7)) begin
            errors++; $display("FAIL stop_beat%0d: data=%h last=%b, required data=%h last=%b",
                               k, dq[k], lq[k], model(2'd0, seed, k), (k % 8 == 7));
         end
      end
   endtask

   task automatic test_modes();
      bit ok; logic [15:0] pc, len, num, gap; logic [31:0] seed; logic [1:0] m;
      logic [31:0] w [3];
      logic [31:0] a [4];
      w = '{32'h80000000, 32'h00000001, 32'h00000002};
      a = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h5A5A5A5A};
      clear_mon();
      start_run(2'd1, 32'h80000000, 16'd3, 16'd1, 16'd0);
      wait_done(50, ok, pc);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (!ok || dq.size() != 3 || dq[k] !== w[k]) begin
            errors++; $display("FAIL walk_beat%0d: beats=%0d data=%h, required %h", k, dq.size(), dq[k], w[k]);
         end
      end
      clear_mon();
      start_run(2'd3, 32'hA5A5A5A5, 16'd4, 16'd1, 16'd0);
      wait_done(50, ok, pc);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (!ok || dq.size() != 4 || dq[k] !== a[k]) begin
            errors++; $display("FAIL alt_beat%0d: beats=%0d data=%h, required %h", k, dq.size(), dq[k], a[k]);
         end
      end
      // randomized runs, each with an ignored cfg_start mid-run
      for (int r = 0; r < 5; r++) begin
         m = 2'($urandom); seed = $urandom;
         len = 16'($urandom_range(1, 5)); num = 16'($urandom_range(1, 3));
         gap = 16'($urandom_range(0, 3));
         clear_mon();
         start_run(m, seed, len, num, gap);
         cfg_start = 1'b1; cfg_seed = ~seed; cfg_pkt_len = len + 16'd2;
         @(posedge ACLK); #1;
         cfg_start = 1'b0;
         wait_done(200, ok, pc);
         checks++;
         if (!ok || pc !== num || dq.size() != int'(num) * int'(len)) begin
            errors++; $display("FAIL rand%0d_count: done_seen=%0d cnt=%0d beats=%0d, required cnt=%0d beats=%0d",
                               r, ok, pc, dq.size(), num, int'(num) * int'(len));
         end
         for (int k = 0; k < dq.size(); k++) begin
            checks++;
            if (dq[k] !== model(m, seed, k) || lq[k] !== (k % int'(len) == int'(len) - 1)) begin
               errors++; $display("FAIL rand%0d_beat%0d: mode=%0d data=%h last=%b, required data=%h last=%b",
                                  r, k, m, dq[k], lq[k], model(m, seed, k), (k % int'(len) == int'(len) - 1));
            end
`ifdef AXIS_TUSER_EN
            checks++;
            if (uq[k] !== {7'(k / int'(len)), k % int'(len) == 0}) begin
               errors++; $display("FAIL rand%0d_tuser%0d: user=%h, required %h",
                                  r, k, uq[k], {7'(k / int'(len)), k % int'(len) == 0});
            end
`endif
         end
      end
      // zero length start is rejected
      clear_mon();
      start_run(2'd0, 32'h1234, 16'd0, 16'd1, 16'd0);
      repeat (3) @(negedge ACLK);
      checks++;
      if (busy !== 1'b0 || dq.size() != 0) begin
         errors++; $display("FAIL len0_ignored: busy=%b beats=%0d, required 0/0", busy, dq.size());
      end
   endtask

   task automatic test_reset_mid();
      bit ok; logic [15:0] pc; logic [31:0] seed;
      seed = $urandom;
      clear_mon();
      start_run(2'd0, seed, 16'd6, 16'd1, 16'd0);
      @(posedge ACLK); #1;         // second beat on the bus
      ARESETN = 1'b0;
      #1;
      checks++;
      if (M_AXIS_TVALID !== 1'b0 || M_AXIS_TLAST !== 1'b0 || busy !== 1'b0 || pkt_count !== 16'd0) begin
         errors++; $display("FAIL reset_mid: valid=%b last=%b busy=%b cnt=%0d, required 0/0/0/0",
                            M_AXIS_TVALID, M_AXIS_TLAST, busy, pkt_count);
      end
      checks++;
      if (dq.size() != 1 || lq[0] !== 1'b0) begin
         errors++; $display("FAIL reset_mid_beats: beats=%0d, required 1 without last", dq.size());
      end
      @(posedge ACLK); #1;
      ARESETN = 1'b1;
      clear_mon();
      start_run(2'd0, seed, 16'd6, 16'd1, 16'd0);
      wait_done(50, ok, pc);
      checks++;
      if (!ok || pc !== 16'd1 || dq.size() != 6) begin
         errors++; $display("FAIL reset_restart: done_seen=%0d cnt=%0d beats=%0d, required 1/1/6", ok, pc, dq.size());
      end
      for (int k = 0; k < dq.size(); k++) begin
         checks++;
         if (dq[k] !== seed + 32'(k) || lq[k] !== (k == 5)) begin
            errors++; $display("FAIL restart_beat%0d: data=%h last=%b, required data=%h last=%b",
                               k, dq[k], lq[k], seed + 32'(k), (k == 5));
         end
      end
   endtask

   initial begin
      test_reset();
      test_counter();
      test_backpressure();
      test_gap_wrap();
      test_stop();
      test_modes();
      test_reset_mid();
      repeat (2) @(posedge ACLK);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
